// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_seq
//  Brief    : Instruction-fetch sequencer: owns the PC, runs the imem
//             req/ack handshake, offers instructions to decode, and flags
//             fetch timeouts and misaligned branch targets.
//  Revision : 1.0
// ============================================================================
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc,
  input  logic [31:0] npc,
  output logic        fetch_err,
  output logic [31:0] ret_cnt
);

  localparam int           c_CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t            r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_ins;
  logic [31:0]       r_ret_cnt;
  logic [c_CW-1:0]   r_wait;
  logic              r_im_req;
  logic              r_ins_valid;
  logic              r_fetch_err;

  logic              w_npc_misaligned;

  assign w_npc_misaligned = (npc[1:0] != 2'b00);

  // Moore outputs are registered alongside the state so each one always
  // reflects the state the FSM is currently in.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_RST;
      r_pc        <= RESET_PC;
      r_ins       <= '0;
      r_ret_cnt   <= '0;
      r_wait      <= '0;
      r_im_req    <= 1'b0;
      r_ins_valid <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state  <= S_FETCH;
          r_wait   <= '0;
          r_im_req <= 1'b1;
        end

        S_FETCH: begin
          if (im_ack) begin
            r_ins       <= im_rdata;
            r_wait      <= '0;
            r_state     <= S_HOLD;
            r_im_req    <= 1'b0;
            r_ins_valid <= 1'b1;
          end else if (r_wait == c_WAIT_LAST) begin
            r_state     <= S_ERR;
            r_im_req    <= 1'b0;
            r_fetch_err <= 1'b1;
          end else begin
            r_wait <= r_wait + c_CW'(1);
          end
        end

        S_HOLD: begin
          if (ins_ready) begin
            r_pc        <= npc;
            r_ret_cnt   <= r_ret_cnt + 32'd1;
            r_ins_valid <= 1'b0;
            // A misaligned target is latched into the PC but never requested.
            if (w_npc_misaligned) begin
              r_state     <= S_ERR;
              r_fetch_err <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_im_req <= 1'b1;
            end
          end
        end

        S_ERR: begin
          r_state <= S_ERR;
        end

        default: begin
          r_state     <= S_ERR;
          r_im_req    <= 1'b0;
          r_ins_valid <= 1'b0;
          r_fetch_err <= 1'b1;
        end
      endcase
    end
  end

  assign im_req    = r_im_req;
  assign im_addr   = r_pc;
  assign ins_valid = r_ins_valid;
  assign ins       = r_ins;
  assign pc        = r_pc;
  assign fetch_err = r_fetch_err;
  assign ret_cnt   = r_ret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_seq
//  Brief    : Self-checking bench for fetch_seq with a transaction-level model.
//  Revision : 1.0
// ============================================================================
module tb_fetch_seq;

  localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rstn, im_ack, ins_ready;
  logic [31:0] im_rdata, npc;
  logic        im_req, ins_valid, fetch_err;
  logic [31:0] im_addr, ins, pc, ret_cnt;

  logic        rstn_b, im_ack_b, ins_ready_b;
  logic [31:0] im_rdata_b, npc_b;
  logic        im_req_b, ins_valid_b, fetch_err_b;
  logic [31:0] im_addr_b, ins_b, pc_b, ret_cnt_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  fetch_seq #(.RESET_PC(c_RESET_PC), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins(ins), .pc(pc), .npc(npc),
    .fetch_err(fetch_err), .ret_cnt(ret_cnt)
  );

  fetch_seq #(.RESET_PC(c_RESET_PC), .TIMEOUT(4)) dut_to (
    .clk(clk), .rstn(rstn_b), .im_req(im_req_b), .im_addr(im_addr_b),
    .im_ack(im_ack_b), .im_rdata(im_rdata_b), .ins_valid(ins_valid_b),
    .ins_ready(ins_ready_b), .ins(ins_b), .pc(pc_b), .npc(npc_b),
    .fetch_err(fetch_err_b), .ret_cnt(ret_cnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch transaction: ack on request cycle delay+1, stall decode
  // for 'stall' cycles, then hand over 'next' as the new PC.
  task automatic fetch_txn(input int delay, input logic [31:0] data, input int stall,
                           input logic [31:0] next, output int req_cycles,
                           output logic [31:0] addr_seen, output logic addr_ok,
                           output logic [31:0] ins_seen, output logic valid_seen,
                           output logic stall_ok, output logic hung);
    logic [31:0] pc0, ins0, cnt0;
    int budget;
    req_cycles = 0; addr_ok = 1'b1; hung = 1'b0; budget = 0;
    addr_seen = im_addr;
    while (im_req === 1'b1 && budget < 300) begin
      req_cycles++; budget++;
      if (im_addr !== addr_seen || pc !== addr_seen) addr_ok = 1'b0;
      im_ack   = (req_cycles == delay + 1);
      im_rdata = im_ack ? data : $urandom;
      step();
    end
    im_ack = 1'b0;
    if (budget >= 300) hung = 1'b1;
    valid_seen = ins_valid;
    ins_seen   = ins;
    pc0 = pc; ins0 = ins; cnt0 = ret_cnt; stall_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      ins_ready = 1'b0; npc = $urandom; im_ack = 1'($urandom); im_rdata = $urandom;
      step();
      if (ins !== ins0 || pc !== pc0 || ret_cnt !== cnt0 || im_req !== 1'b0 || ins_valid !== 1'b1)
        stall_ok = 1'b0;
    end
    im_ack = 1'b0; ins_ready = 1'b1; npc = next;
    step();
    ins_ready = 1'b0; npc = $urandom;
  endtask

  task automatic test_reset();
    rstn = 1'b0; im_ack = 1'b0; ins_ready = 1'b0; im_rdata = '0; npc = '0;
    step(); step();
    total++;
    if (im_req !== 1'b0 || ins_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== c_RESET_PC ||
        ins !== 32'd0 || ret_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: req=%b valid=%b err=%b pc=%h ins=%h cnt=%0d, need 0 0 0 %h 0 0",
               im_req, ins_valid, fetch_err, pc, ins, ret_cnt, c_RESET_PC);
    end
    rstn = 1'b1;
    step();
    total++;
    if (im_req !== 1'b1 || im_addr !== c_RESET_PC) begin
      bad++;
      $display("FAIL first_req: req=%b addr=%h, need 1 %h", im_req, im_addr, c_RESET_PC);
    end
    exp_pc = c_RESET_PC; exp_ret = 0;
  endtask

  task automatic test_straight();
    int rc; logic [31:0] a, is; logic aok, v, sok, h; int t0;
    for (int k = 0; k < 3; k++) begin
      t0 = $time;
      fetch_txn(0, 32'h1000_0000 + k, 0, exp_pc + 32'd4, rc, a, aok, is, v, sok, h);
      total++;
      if (a !== exp_pc || !aok || rc != 1 || ($time - t0) != 20) begin
        bad++;
        $display("FAIL straight_addr%0d: addr=%h reqcyc=%0d span=%0t, need %h 1 20", k, a, rc, $time - t0, exp_pc);
      end
      exp_pc = exp_pc + 32'd4; exp_ret++;
    end
    total++;
    if (ret_cnt !== 32'd3 || pc !== 32'h0000_300C || im_req !== 1'b1) begin
      bad++;
      $display("FAIL straight_end: cnt=%0d pc=%h req=%b, need 3 0000300c 1", ret_cnt, pc, im_req);
    end
  endtask

  task automatic test_slow();
    int rc; logic [31:0] a, is; logic aok, v, sok, h;
    fetch_txn(4, 32'hCAFE_0001, 0, exp_pc + 32'd4, rc, a, aok, is, v, sok, h);
    total++;
    if (rc != 5 || v !== 1'b1 || is !== 32'hCAFE_0001 || !aok) begin
      bad++;
      $display("FAIL slow_mem: reqcyc=%0d valid=%b ins=%h, need 5 1 cafe0001", rc, v, is);
    end
    exp_pc = exp_pc + 32'd4; exp_ret++;
  endtask

  task automatic test_stall();
    int rc; logic [31:0] a, is; logic aok, v, sok, h;
    fetch_txn(1, 32'h5A5A_A5A5, 4, 32'h0000_4000, rc, a, aok, is, v, sok, h);
    exp_ret++;
    total++;
    if (!sok || is !== 32'h5A5A_A5A5) begin
      bad++;
      $display("FAIL stall_stable: stable=%b ins=%h, need 1 5a5aa5a5", sok, is);
    end
    total++;
    if (pc !== 32'h0000_4000 || ret_cnt !== exp_ret || im_req !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: pc=%h cnt=%0d req=%b, need 00004000 %0d 1", pc, ret_cnt, im_req, exp_ret);
    end
    exp_pc = 32'h0000_4000;
  endtask

  task automatic test_random();
    int rc, d, s; logic [31:0] a, is, dat, nx; logic aok, v, sok, h;
    for (int k = 0; k < 25; k++) begin
      d = $urandom_range(0, 12); s = $urandom_range(0, 3);
      dat = $urandom; nx = $urandom & 32'hFFFF_FFFC;
      fetch_txn(d, dat, s, nx, rc, a, aok, is, v, sok, h);
      exp_ret++;
      total++;
      if (h || a !== exp_pc || !aok || rc != d + 1 || v !== 1'b1 || is !== dat || !sok ||
          ret_cnt !== exp_ret || pc !== nx || fetch_err !== 1'b0) begin
        bad++;
        $display("FAIL random_txn%0d: addr=%h reqcyc=%0d ins=%h cnt=%0d pc=%h, need %h %0d %h %0d %h",
                 k, a, rc, is, ret_cnt, pc, exp_pc, d + 1, dat, exp_ret, nx);
      end
      exp_pc = nx;
    end
  endtask

  task automatic test_reset_midfetch();
    total++;
    if (im_req !== 1'b1 || ret_cnt === 32'd0) begin
      bad++;
      $display("FAIL midfetch_pre: req=%b cnt=%0d, need 1 nonzero", im_req, ret_cnt);
    end
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF; rstn = 1'b0;
    step();
    im_ack = 1'b0; rstn = 1'b1;
    total++;
    if (ins !== 32'd0 || ret_cnt !== 32'd0 || pc !== c_RESET_PC || fetch_err !== 1'b0 ||
        ins_valid !== 1'b0 || im_req !== 1'b0) begin
      bad++;
      $display("FAIL midfetch_reset: ins=%h cnt=%0d pc=%h err=%b valid=%b req=%b, need 0 0 %h 0 0 0",
               ins, ret_cnt, pc, fetch_err, ins_valid, im_req, c_RESET_PC);
    end
    step();
    exp_pc = c_RESET_PC; exp_ret = 0;
  endtask

  task automatic test_misaligned();
    int rc, reqs; logic [31:0] a, is; logic aok, v, sok, h, ok;
    fetch_txn(0, 32'h0BAD_0000, 0, 32'h0000_3002, rc, a, aok, is, v, sok, h);
    total++;
    if (pc !== 32'h0000_3002 || fetch_err !== 1'b1 || im_req !== 1'b0 || ret_cnt !== 32'd1) begin
      bad++;
      $display("FAIL misalign_latch: pc=%h err=%b req=%b cnt=%0d, need 00003002 1 0 1", pc, fetch_err, im_req, ret_cnt);
    end
    reqs = 0; ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      im_ack = 1'($urandom); ins_ready = 1'($urandom); npc = $urandom;
      step();
      if (im_req === 1'b1) reqs++;
      if (fetch_err !== 1'b1 || pc !== 32'h0000_3002 || ins_valid !== 1'b0) ok = 1'b0;
    end
    im_ack = 1'b0; ins_ready = 1'b0;
    total++;
    if (reqs != 0 || !ok) begin
      bad++;
      $display("FAIL misalign_hold: reqs=%0d sticky=%b, need 0 1", reqs, ok);
    end
  endtask

  task automatic test_reset_from_err();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    total++;
    if (pc !== c_RESET_PC || fetch_err !== 1'b0 || ret_cnt !== 32'd0 || ins !== 32'd0) begin
      bad++;
      $display("FAIL err_reset: pc=%h err=%b cnt=%0d ins=%h, need %h 0 0 0", pc, fetch_err, ret_cnt, ins, c_RESET_PC);
    end
    step();
    total++;
    if (im_req !== 1'b1 || im_addr !== c_RESET_PC) begin
      bad++;
      $display("FAIL err_restart: req=%b addr=%h, need 1 %h", im_req, im_addr, c_RESET_PC);
    end
  endtask

  task automatic test_timeout();
    int n; logic early_err, ok;
    rstn_b = 1'b0; step(); step();
    rstn_b = 1'b1; step();
    n = 0; early_err = 1'b0;
    while (im_req_b === 1'b1 && n < 50) begin
      if (fetch_err_b !== 1'b0 || im_addr_b !== c_RESET_PC) early_err = 1'b1;
      n++;
      step();
    end
    total++;
    if (n != 4 || early_err) begin
      bad++;
      $display("FAIL timeout_len: reqcyc=%0d early=%b, need 4 0", n, early_err);
    end
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (fetch_err_b !== 1'b1 || im_req_b !== 1'b0 || pc_b !== c_RESET_PC || ins_valid_b !== 1'b0) ok = 1'b0;
      im_ack_b = 1'($urandom); ins_ready_b = 1'($urandom); npc_b = $urandom;
      step();
    end
    total++;
    if (!ok || fetch_err_b !== 1'b1 || im_req_b !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err: err=%b req=%b pc=%h sticky=%b, need 1 0 %h 1", fetch_err_b, im_req_b, pc_b, ok, c_RESET_PC);
    end
  endtask

  initial begin
    rstn_b = 1'b0; im_ack_b = 1'b0; ins_ready_b = 1'b0; im_rdata_b = '0; npc_b = '0;
    test_reset();
    test_straight();
    test_slow();
    test_stall();
    test_random();
    test_reset_midfetch();
    test_misaligned();
    test_reset_from_err();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It presents each fetched instruction to decode with a valid/ready handshake and, on acceptance, loads the PC from the combinational next-PC unit (`npc`). It sits between the PC register position of the single-cycle datapath and an instruction memory that may take multiple cycles. It also detects fetch timeouts and misaligned targets.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `TIMEOUT`, 16: maximum request cycles without `im_ack` before the block enters the error state. Legal range 2..256.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset. Synchronous, active-low, sampled on the rising edge of `clk`.
- `im_req`  out  1  fetch request to instruction memory.
- `im_addr`  out  32  fetch address. Always equals `pc`.
- `im_ack`  in  1  memory accepts the request; `im_rdata` is valid in the same cycle.
- `im_rdata`  in  32  instruction word.
- `ins_valid`  out  1  `ins`/`pc` pair is offered to decode.
- `ins_ready`  in  1  decode accepts the offered instruction.
- `ins`  out  32  registered instruction.
- `pc`  out  32  address of `ins`. This is the current PC.
- `npc`  in  32  next PC from the NPC unit. Sampled only on the decode handshake.
- `fetch_err`  out  1  sticky error flag.
- `ret_cnt`  out  32  number of instructions accepted by decode.

## Operation

States: `RST`, `FETCH`, `HOLD`, `ERR`.

- **Reset** (`rstn`=0 at a clock edge):
  - `state`=`RST`, `pc`=`RESET_PC`, `ins`=0, `ret_cnt`=0, wait counter=0, `fetch_err`=0.
  - Reset overrides every other event, including in-flight `im_ack` and `ERR`.
- **`RST`**: all handshake outputs are 0. Moves to `FETCH` on the next edge.
- **`FETCH`**:
  - `im_req`=1, `im_addr`=`pc`.
  - If `im_ack`=1: `ins` <= `im_rdata`, go to `HOLD`, wait counter <= 0.
  - Else, if wait counter == `TIMEOUT`-1: go to `ERR`.
  - Else: wait counter increments.
  - Net effect: an ack in any of the first `TIMEOUT` request cycles is accepted.
- **`HOLD`**:
  - `ins_valid`=1, `im_req`=0.
  - When `ins_ready`=1 (handshake):
    - `pc` <= `npc`.
    - `ret_cnt` <= `ret_cnt`+1, wrapping modulo 2^32.
    - If `npc[1:0]` != 2'b00, go to `ERR`; else go to `FETCH`.
  - When `ins_ready`=0: `ins` and `pc` stay stable; the state stays `HOLD`.
- **`ERR`**:
  - `fetch_err`=1, `im_req`=0, `ins_valid`=0.
  - `pc` holds the faulting value: the misaligned target, or the address that timed out.
  - Only `rstn` exits this state.
- **General rules**:
  - `im_ack` is ignored in every state except `FETCH`.
  - `ins_ready` is ignored outside `HOLD`.
  - `npc` is never sampled outside the `HOLD` handshake.
- **Outputs and arithmetic**:
  - `im_req`, `ins_valid` and `fetch_err` are decoded from the registered state (Moore outputs).
  - `ret_cnt` and `pc` arithmetic is unsigned 32-bit with no saturation.
  - The wait counter is `$clog2(TIMEOUT)` bits wide.

## Timing

- **After reset release**: first edge with `rstn`=1 goes to `FETCH`, so `im_req` rises one cycle after reset deasserts.
- **Fetch latency**: the ack in cycle N gives `ins_valid`=1 in cycle N+1.
- **Best-case throughput**: one instruction every 2 cycles (`FETCH` with immediate ack, then `HOLD` with `ins_ready`=1).
- **New PC timing**: the `pc` update from `npc` is visible in the cycle after the handshake, together with `im_req`=1 for that address.
- **Timeout**: with no ack, `im_req` stays high for exactly `TIMEOUT` cycles, then `fetch_err`=1 from the following cycle on.
- **Misalignment**: the misaligned `npc` is latched into `pc`, and `fetch_err` rises the next cycle. No request is ever issued to a misaligned address.
- **Reset during `FETCH` with `im_ack`=1 in the same cycle**: reset wins. `ins` stays 0 and `ret_cnt` stays 0.

## Test plan

- **Reset + straight-line fetch**:
  - Stimulus: `RESET_PC`=0x3000. Memory acks immediately. `ins_ready`=1. `npc`=`pc`+4.
  - Required: `im_addr` sequence 0x3000, 0x3004, 0x3008 on every other cycle. `ret_cnt`=3 after 3 handshakes.
- **Slow memory**:
  - Stimulus: ack arrives after 5 request cycles.
  - Required: `im_req` high for exactly 5 cycles. `ins_valid` rises the cycle after the ack. `ins` equals `im_rdata` at the ack.
- **Decode stall**:
  - Stimulus: hold `ins_ready`=0 for 4 cycles in `HOLD`, and change `npc` and `im_ack` during the stall.
  - Required: `ins`, `pc` and `ret_cnt` stay unchanged, and `im_req`=0. On release, `pc` takes the `npc` value from the release cycle.
- **Timeout** (`TIMEOUT`=4, never ack):
  - Required: `im_req` high for 4 cycles, then `fetch_err`=1 and `im_req`=0 persistently. `pc` keeps the stuck address.
- **Misaligned jump**:
  - Stimulus: handshake with `npc`=0x3002.
  - Required: `pc`=0x3002, `fetch_err`=1 the next cycle, and no request is ever issued.
- **Reset from `ERR` and mid-fetch**:
  - Stimulus: assert `rstn`=0 for 1 cycle while in `ERR`. Separately, assert it in the same cycle as `im_ack`.
  - Required (both cases): `pc`=`RESET_PC`, `fetch_err`=0, `ret_cnt`=0, and `ins`=0 after reset.
